// File: rtl/sata_pkg.sv
// Shared definitions for the SATA software-reset sequencer.
// Holds FIS type codes, the device-control SRST bit, the ATA status ERR
// bit index, the sequencer state encoding and a helper that builds the
// words of a Register H2D FIS.
package sata_pkg;

  localparam logic [7:0] FIS_REG_H2D  = 8'h27;
  localparam logic [7:0] FIS_REG_D2H  = 8'h34;
  localparam logic [7:0] CTRL_SRST    = 8'h04;
  localparam int         STAT_ERR     = 0;
  // Both Register FIS types are five dwords long, so index 4 is the last one.
  localparam logic [2:0] FIS_LAST_IDX = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_SET = 3'd1,
    ST_HOLD     = 3'd2,
    ST_SEND_CLR = 3'd3,
    ST_WAIT_D2H = 3'd4,
    ST_FINISH   = 3'd5
  } srst_state_t;

  // Word idx of a Register H2D FIS with C = 0 and the given control byte.
  function automatic logic [31:0] h2d_word(input logic [2:0] idx,
                                           input logic [7:0] control);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {24'h00_0000, FIS_REG_H2D};
      3'd3:    w = {control, 8'h00, 16'h0000};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sata_d2h_parse.sv
// Register D2H FIS receive parser.
// Tracks the word index of the incoming receive stream, tags frames whose
// FIS type is Register D2H, collects status and signature bytes, and
// raises cap_valid for one cycle when a well-formed five-word D2H frame
// ends while the sequencer is waiting for it (armed).
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   rx_data/valid/last  - link receive word stream (no backpressure)
//   armed               - high while the sequencer waits for the D2H FIS
//   cap_valid           - combinational pulse on the capturing rx_last
//   signature, status   - fields of the frame being received
module sata_d2h_parse
  import sata_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic        armed,
  output logic        cap_valid,
  output logic [31:0] signature,
  output logic [7:0]  status
);

  logic [2:0]  idx_r;
  logic        match_r;
  logic        long_r;
  logic [7:0]  status_r;
  logic [23:0] lba_r;
  logic [7:0]  count_r;
  logic        unused_s;

  // Bytes of the D2H FIS that the sequencer does not report.
  assign unused_s = ^{rx_data[31:24], rx_data[15:8]};

  // Word index, type match and overlength tracking for the current frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r   <= 3'd0;
      match_r <= 1'b0;
      long_r  <= 1'b0;
    end else if (rx_valid) begin
      if (rx_last) begin
        idx_r   <= 3'd0;
        match_r <= 1'b0;
        long_r  <= 1'b0;
      end else begin
        if (idx_r == 3'd0) begin
          match_r <= (rx_data[7:0] == FIS_REG_D2H);
        end
        // The index saturates at the last slot; any further non-final
        // word marks the frame as too long so it can never be captured.
        if (idx_r == FIS_LAST_IDX) begin
          long_r <= 1'b1;
        end else begin
          idx_r <= idx_r + 3'd1;
        end
      end
    end
  end

  // Field collection; values only matter when cap_valid fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_r <= 8'h00;
      lba_r    <= 24'h00_0000;
      count_r  <= 8'h00;
    end else if (rx_valid) begin
      case (idx_r)
        3'd0:    status_r <= rx_data[23:16];
        3'd1:    lba_r    <= rx_data[23:0];
        3'd3:    count_r  <= rx_data[7:0];
        default: count_r  <= count_r;
      endcase
    end
  end

  // A capture needs a matched, exactly five-word frame ending while armed.
  always_comb begin
    cap_valid = 1'b0;
    if (armed && rx_valid && rx_last && (idx_r == FIS_LAST_IDX) &&
        match_r && !long_r) begin
      cap_valid = 1'b1;
    end else begin
      cap_valid = 1'b0;
    end
  end

  assign signature = {lba_r, count_r};
  assign status    = status_r;

endmodule

// File: rtl/sata_srst_ctrl.sv
// ATA software-reset sequencer on the SATA transport layer.
// On start it sends a Register H2D FIS with SRST set, holds for
// HOLD_CYCLES, sends a second Register H2D FIS with SRST cleared, then
// waits for the device's Register D2H FIS and reports signature/status.
// Optional feature macro: SATA_SRST_TIMEOUT_EN - bounds the D2H wait to
// TIMEOUT_CYCLES and ends with err = 1, status = 8'hFF on expiry.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   start                       - one-cycle sequence request (IDLE only)
//   busy, done, err             - sequence status (done is a pulse)
//   signature, status           - captured D2H fields
//   tx_data/valid/last, tx_ready - transmit word stream to the link
//   rx_data/valid/last          - receive word stream from the link
module sata_srst_ctrl
  import sata_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 32'd5000,
  parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] signature,
  output logic [7:0]  status,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_last
);

  // One down-counter serves both the hold interval and the D2H timeout.
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ?
                                    HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int          CNT_W   = (CNT_MAX > 32'd1) ? $clog2(CNT_MAX) : 1;

  srst_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       widx_r;
  logic [2:0]       next_idx_s;
  logic [7:0]       ctrl_byte_s;
  logic             armed_s;
  logic             cap_valid_s;
  logic [31:0]      cap_sig_s;
  logic [7:0]       cap_status_s;

  assign next_idx_s = widx_r + 3'd1;
  assign armed_s    = (state_r == ST_WAIT_D2H);

  // Control byte of the FIS currently being sent.
  always_comb begin
    ctrl_byte_s = 8'h00;
    if (state_r == ST_SEND_SET) begin
      ctrl_byte_s = CTRL_SRST;
    end else begin
      ctrl_byte_s = 8'h00;
    end
  end

  sata_d2h_parse u_parse (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_last   (rx_last),
    .armed     (armed_s),
    .cap_valid (cap_valid_s),
    .signature (cap_sig_s),
    .status    (cap_status_s)
  );

  // Sequencer FSM with registered transmit stream and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      widx_r    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      signature <= 32'h0000_0000;
      status    <= 8'h00;
      tx_data   <= 32'h0000_0000;
      tx_valid  <= 1'b0;
      tx_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_SEND_SET;
            busy     <= 1'b1;
            err      <= 1'b0;
            widx_r   <= 3'd0;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            tx_data  <= h2d_word(3'd0, CTRL_SRST);
          end
        end
        ST_SEND_SET, ST_SEND_CLR: begin
          if (tx_valid && tx_ready) begin
            if (widx_r == FIS_LAST_IDX) begin
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              tx_data  <= 32'h0000_0000;
              if (state_r == ST_SEND_SET) begin
                state_r <= ST_HOLD;
                cnt_r   <= CNT_W'(HOLD_CYCLES - 32'd1);
              end else begin
                state_r <= ST_WAIT_D2H;
`ifdef SATA_SRST_TIMEOUT_EN
                cnt_r   <= CNT_W'(TIMEOUT_CYCLES - 32'd1);
`endif
              end
            end else begin
              widx_r  <= next_idx_s;
              tx_data <= h2d_word(next_idx_s, ctrl_byte_s);
              tx_last <= (next_idx_s == FIS_LAST_IDX);
            end
          end
        end
        ST_HOLD: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r  <= ST_SEND_CLR;
            widx_r   <= 3'd0;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            tx_data  <= h2d_word(3'd0, 8'h00);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_WAIT_D2H: begin
          // A capture on the same cycle as counter expiry takes priority.
          if (cap_valid_s) begin
            signature <= cap_sig_s;
            status    <= cap_status_s;
            err       <= cap_status_s[STAT_ERR];
            state_r   <= ST_FINISH;
          end
`ifdef SATA_SRST_TIMEOUT_EN
          else if (cnt_r == {CNT_W{1'b0}}) begin
            status  <= 8'hFF;
            err     <= 1'b1;
            state_r <= ST_FINISH;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
`endif
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          tx_valid <= 1'b0;
          tx_last  <= 1'b0;
          tx_data  <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sata_srst_ctrl.sv
// Directed self-checking bench for sata_srst_ctrl (HOLD_CYCLES = 8).
// The timeout scenario is compiled only with SATA_SRST_TIMEOUT_EN.
module tb_sata_srst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, err;
  logic [31:0] signature;
  logic [7:0]  status;
  logic [31:0] tx_data;
  logic        tx_valid, tx_last, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_last;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [32:0] hs_q[$];

  localparam logic [31:0] F_SET [5] = '{32'h0000_0027, 32'h0, 32'h0, 32'h0400_0000, 32'h0};
  localparam logic [31:0] F_CLR [5] = '{32'h0000_0027, 32'h0, 32'h0, 32'h0000_0000, 32'h0};

  sata_srst_ctrl #(.HOLD_CYCLES(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .err(err), .signature(signature), .status(status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_last(rx_last)
  );

  always #5 clk = ~clk;

  // Record accepted transmit words and done pulses at the active edge.
  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready) hs_q.push_back({tx_last, tx_data});
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks five consecutive words presented with tx_ready high.
  task automatic expect_frame(input logic set);
    for (int i = 0; i < 5; i++) begin
      chk("frm_valid", 32'(tx_valid), 32'd1);
      chk("frm_data", tx_data, set ? F_SET[i] : F_CLR[i]);
      chk("frm_last", 32'(tx_last), (i == 4) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  // Sends an rx frame: type, status, signature, number of words.
  task automatic send_rx(input logic [7:0] ftype, input logic [7:0] st,
                         input logic [31:0] sig, input int nw);
    logic [31:0] w;
    for (int i = 0; i < nw; i++) begin
      case (i)
        0:       w = {8'h00, st, 8'hA0, ftype};
        1:       w = {8'hE0, sig[31:8]};
        3:       w = {24'hCC_DD00, sig[7:0]};
        default: w = 32'hDEAD_BEEF;
      endcase
      rx_data  = w;
      rx_valid = 1'b1;
      rx_last  = (i == nw - 1);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = 32'h0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_q.size() < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("hs_reached", 32'(hs_q.size()), 32'(target));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int base, d0, n;
    logic [31:0] sd;
    logic        sl, stalled;

    reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
    rx_data = 32'h0; rx_valid = 1'b0; rx_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txl", 32'(tx_last), 32'd0);
    chk("rst_txd", tx_data, 32'd0);
    chk("rst_sig", signature, 32'd0);
    chk("rst_stat", 32'(status), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Nominal sequence with exact cycle timing.
    tx_ready = 1'b1;
    d0 = done_cnt;
    pulse_start();
    chk("nom_busy", 32'(busy), 32'd1);
    expect_frame(1'b1);
    n = 0;
    while (!tx_valid && n < 50) begin n++; @(negedge clk); end
    chk("nom_hold_len", 32'(n), 32'd8);
    expect_frame(1'b0);
    chk("nom_wait_txv", 32'(tx_valid), 32'd0);
    chk("nom_wait_busy", 32'(busy), 32'd1);
    send_rx(8'h34, 8'h50, 32'h0000_0101, 5);
    chk("nom_sig", signature, 32'h0000_0101);
    chk("nom_stat", 32'(status), 32'h50);
    chk("nom_err", 32'(err), 32'd0);
    chk("nom_busy_m1", 32'(busy), 32'd1);
    chk("nom_done_m1", 32'(done), 32'd0);
    @(negedge clk);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_busy_off", 32'(busy), 32'd0);
    @(negedge clk);
    chk("nom_done_once", 32'(done_cnt - d0), 32'd1);

`ifdef SATA_SRST_TIMEOUT_EN
    // No reply: done 101 cycles after entering WAIT_D2H.
    base = hs_q.size();
    tx_ready = 1'b1;
    pulse_start();
    wait_hs(base + 10);
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    chk("to_latency", 32'(n), 32'd101);
    chk("to_err", 32'(err), 32'd1);
    chk("to_stat", 32'(status), 32'hFF);
    chk("to_sig_kept", signature, 32'h0000_0101);
    @(negedge clk);
`endif

    // Backpressure: tx_ready toggles every cycle.
    base = hs_q.size();
    tx_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 45; c++) begin
      tx_ready = c[0];
      stalled = tx_valid && !tx_ready;
      sd = tx_data;
      sl = tx_last;
      @(negedge clk);
      if (stalled) begin
        chk("bp_data_stable", tx_data, sd);
        chk("bp_last_stable", 32'(tx_last), 32'(sl));
      end
    end
    tx_ready = 1'b1;
    chk("bp_words", 32'(hs_q.size() - base), 32'd10);
    chk("bp_w3_set", hs_q[base + 3][31:0], 32'h0400_0000);
    chk("bp_w3_clr", hs_q[base + 8][31:0], 32'h0000_0000);
    chk("bp_last1", 32'(hs_q[base + 4][32]), 32'd1);
    chk("bp_last0", 32'(hs_q[base + 3][32]), 32'd0);
    send_rx(8'h34, 8'h51, 32'h1122_3344, 5);
    wait_done();
    chk("err_set", 32'(err), 32'd1);
    chk("err_stat", 32'(status), 32'h51);
    @(negedge clk);
    pulse_start();
    chk("err_cleared", 32'(err), 32'd0);
    base = hs_q.size();
    wait_hs(base + 9);
    @(negedge clk);

    // Noise rejection.
    send_rx(8'h34, 8'h50, 32'h0000_0101, 5);
    wait_done();
    @(negedge clk);
    base = hs_q.size();
    d0 = done_cnt;
    pulse_start();
    wait_hs(base + 5);
    send_rx(8'h34, 8'h41, 32'hAAAA_AAAA, 5);
    wait_hs(base + 10);
    send_rx(8'h34, 8'h41, 32'hBBBB_BBBB, 3);
    send_rx(8'h39, 8'h41, 32'hCCCC_CCCC, 5);
    send_rx(8'h34, 8'h41, 32'hDDDD_DDDD, 6);
    repeat (3) @(negedge clk);
    chk("noise_busy", 32'(busy), 32'd1);
    chk("noise_no_done", 32'(done_cnt - d0), 32'd0);
    send_rx(8'h34, 8'h50, 32'h1234_5678, 5);
    chk("noise_sig", signature, 32'h1234_5678);
    chk("noise_stat", 32'(status), 32'h50);
    wait_done();
    @(negedge clk);
    chk("noise_done_once", 32'(done_cnt - d0), 32'd1);

    // Reset during HOLD, then a full re-run with a stray start.
    base = hs_q.size();
    pulse_start();
    wait_hs(base + 5);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_txv", 32'(tx_valid), 32'd0);
    chk("mr_sig", signature, 32'd0);
    chk("mr_stat", 32'(status), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    base = hs_q.size();
    d0 = done_cnt;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_hs(base + 10);
    send_rx(8'h34, 8'h50, 32'h0000_0101, 5);
    wait_done();
    repeat (20) @(negedge clk);
    chk("rs_words", 32'(hs_q.size() - base), 32'd10);
    chk("rs_done_once", 32'(done_cnt - d0), 32'd1);
    chk("rs_sig", signature, 32'h0000_0101);
    chk("rs_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
